// File: rtl/dpram_clr_sync_if.sv
// Port bundle for dpram_clr_sync: both user ports plus the status flags.
// master drives addresses, enables and write data; slave is the RAM side.
interface dpram_clr_sync_if #(
    parameter int AW = 10,
    parameter int DW = 9
);
    logic [AW-1:0] addra;
    logic [AW-1:0] addrb;
    logic          cea;
    logic          ceb;
    logic          wea;
    logic          web;
    logic [DW-1:0] dia;
    logic [DW-1:0] dib;
    logic [DW-1:0] doa;
    logic [DW-1:0] dob;
    logic          init_busy;
    logic          collision;

    modport master (
        output addra, addrb, cea, ceb, wea, web, dia, dib,
        input  doa, dob, init_busy, collision
    );

    modport slave (
        input  addra, addrb, cea, ceb, wea, web, dia, dib,
        output doa, dob, init_busy, collision
    );
endinterface

// File: rtl/dpram_clr_sync.sv
// Single-clock true dual-port RAM with a post-reset clear sweep, selectable
// write mode, optional output register and same-address collision flag.
module dpram_clr_sync #(
    parameter int            AW             = 10,
    parameter int            DW             = 9,
    parameter int            OUTREG         = 0,
    parameter string         WRITEMODE      = "NORMAL",
    parameter int            CLEAR_ON_RESET = 1,
    parameter logic [DW-1:0] CLEAR_VAL      = '0
) (
    input logic             clk,
    input logic             rst,
    dpram_clr_sync_if.slave bus
);
    localparam int DEPTH      = 1 << AW;
    localparam bit WM_THROUGH = (WRITEMODE == "WRITETHROUGH");
    localparam bit WM_RBW     = (WRITEMODE == "READBEFOREWRITE");

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state_reg;
    logic [AW-1:0] ptr_reg;
    logic          init_busy_reg;
    logic          collision_reg;

    logic [DW-1:0] mem [DEPTH];

    // Index 0 is port A, index 1 is port B.
    logic [AW-1:0] addr [2];
    logic [DW-1:0] din  [2];
    logic          ce   [2];
    logic          we   [2];
    logic [DW-1:0] dout [2];

    assign addr[0] = bus.addra;
    assign addr[1] = bus.addrb;
    assign din[0]  = bus.dia;
    assign din[1]  = bus.dib;
    assign ce[0]   = bus.cea;
    assign ce[1]   = bus.ceb;
    assign we[0]   = bus.wea;
    assign we[1]   = bus.web;

    logic          active;
    logic          clearing;
    logic          same_addr;
    logic          conflict;
    logic          wr_a;
    logic          wr_b;
    logic [AW-1:0] wa_addr;
    logic [DW-1:0] wa_data;

    // The clear sweep borrows port A's write path; B loses a same-address
    // double write so A's data is the one stored.
    always_comb begin
        active    = (state_reg == IDLE);
        clearing  = (state_reg == CLEAR) && !rst;
        same_addr = (addr[0] == addr[1]);
        conflict  = active && ce[0] && ce[1] && same_addr && (we[0] || we[1]);
        wr_a      = clearing || (!rst && active && ce[0] && we[0]);
        wr_b      = !rst && active && ce[1] && we[1] && !(ce[0] && we[0] && same_addr);
        wa_addr   = clearing ? ptr_reg : addr[0];
        wa_data   = clearing ? CLEAR_VAL : din[0];
    end

    always_ff @(posedge clk) begin
        if (wr_a) begin
            mem[wa_addr] <= wa_data;
        end
        if (wr_b) begin
            mem[addr[1]] <= din[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            ptr_reg       <= '0;
            init_busy_reg <= (CLEAR_ON_RESET != 0);
            collision_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    init_busy_reg <= 1'b0;
                    collision_reg <= conflict;
                end
                CLEAR: begin
                    collision_reg <= 1'b0;
                    ptr_reg       <= ptr_reg + 1'b1;
                    if (ptr_reg == {AW{1'b1}}) begin
                        state_reg     <= IDLE;
                        init_busy_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    init_busy_reg <= 1'b0;
                    collision_reg <= 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DW-1:0] rd_reg;

            // A NORMAL-mode write leaves rd_reg untouched so the port output holds.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_reg <= '0;
                end else if (active && ce[gi]) begin
                    if (!we[gi] || WM_RBW) begin
                        rd_reg <= mem[addr[gi]];
                    end else if (WM_THROUGH) begin
                        rd_reg <= din[gi];
                    end
                end
            end

            if (OUTREG != 0) begin : g_outreg
                logic [DW-1:0] out_reg;
                logic          ce_d_reg;

                // Second stage advances one cycle behind the access that loaded rd_reg.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        out_reg  <= '0;
                        ce_d_reg <= 1'b0;
                    end else begin
                        ce_d_reg <= active && ce[gi];
                        if (ce_d_reg) begin
                            out_reg <= rd_reg;
                        end
                    end
                end

                assign dout[gi] = out_reg;
            end else begin : g_direct
                assign dout[gi] = rd_reg;
            end
        end
    endgenerate

    assign bus.doa       = dout[0];
    assign bus.dob       = dout[1];
    assign bus.init_busy = init_busy_reg;
    assign bus.collision = collision_reg;
endmodule

// File: tb/tb_dpram_clr_sync.sv
// Directed bench: three 16-word instances (NORMAL, WRITETHROUGH, and
// READBEFOREWRITE with output register) sharing one stimulus stream.
module tb_dpram_clr_sync;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    dpram_clr_sync_if #(.AW(4), .DW(9)) bus0 ();
    dpram_clr_sync_if #(.AW(4), .DW(9)) bus1 ();
    dpram_clr_sync_if #(.AW(4), .DW(9)) bus2 ();

    assign bus1.addra = bus0.addra;
    assign bus1.addrb = bus0.addrb;
    assign bus1.cea   = bus0.cea;
    assign bus1.ceb   = bus0.ceb;
    assign bus1.wea   = bus0.wea;
    assign bus1.web   = bus0.web;
    assign bus1.dia   = bus0.dia;
    assign bus1.dib   = bus0.dib;
    assign bus2.addra = bus0.addra;
    assign bus2.addrb = bus0.addrb;
    assign bus2.cea   = bus0.cea;
    assign bus2.ceb   = bus0.ceb;
    assign bus2.wea   = bus0.wea;
    assign bus2.web   = bus0.web;
    assign bus2.dia   = bus0.dia;
    assign bus2.dib   = bus0.dib;

    dpram_clr_sync #(.AW(4), .DW(9), .OUTREG(0), .WRITEMODE("NORMAL"),
                     .CLEAR_ON_RESET(1), .CLEAR_VAL(9'h000))
        u_norm (.clk(clk), .rst(rst), .bus(bus0));
    dpram_clr_sync #(.AW(4), .DW(9), .OUTREG(0), .WRITEMODE("WRITETHROUGH"),
                     .CLEAR_ON_RESET(1), .CLEAR_VAL(9'h000))
        u_wt (.clk(clk), .rst(rst), .bus(bus1));
    dpram_clr_sync #(.AW(4), .DW(9), .OUTREG(1), .WRITEMODE("READBEFOREWRITE"),
                     .CLEAR_ON_RESET(1), .CLEAR_VAL(9'h000))
        u_rbw (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cea;
        logic       wea;
        logic [3:0] addra;
        logic [8:0] dia;
        logic       ceb;
        logic       web;
        logic [3:0] addrb;
        logic [8:0] dib;
        logic [8:0] doa0;
        logic [8:0] dob0;
        logic       col;
        logic [8:0] doa1;
        logic [8:0] doa2;
        logic [8:0] dob2;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic a_ce, input logic a_we, input logic [3:0] a_ad,
                       input logic [8:0] a_d, input logic b_ce, input logic b_we,
                       input logic [3:0] b_ad, input logic [8:0] b_d,
                       input logic [8:0] e_doa0, input logic [8:0] e_dob0,
                       input logic e_col, input logic [8:0] e_doa1,
                       input logic [8:0] e_doa2, input logic [8:0] e_dob2);
        vec_t v;
        v.cea = a_ce;  v.wea = a_we;  v.addra = a_ad; v.dia = a_d;
        v.ceb = b_ce;  v.web = b_we;  v.addrb = b_ad; v.dib = b_d;
        v.doa0 = e_doa0; v.dob0 = e_dob0; v.col = e_col;
        v.doa1 = e_doa1; v.doa2 = e_doa2; v.dob2 = e_dob2;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic a_ce, input logic a_we, input logic [3:0] a_ad,
                         input logic [8:0] a_d, input logic b_ce, input logic b_we,
                         input logic [3:0] b_ad, input logic [8:0] b_d);
        bus0.cea = a_ce;  bus0.wea = a_we;  bus0.addra = a_ad; bus0.dia = a_d;
        bus0.ceb = b_ce;  bus0.web = b_we;  bus0.addrb = b_ad; bus0.dib = b_d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 9'h000, 1'b0, 1'b0, 4'd0, 9'h000);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk9(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Counts busy samples starting from the one just taken after the reset edge.
    task automatic count_busy(input string tag, output int cnt);
        cnt = bus0.init_busy ? 1 : 0;
        for (int k = 0; k < 64; k++) begin
            step();
            if (!bus0.init_busy) break;
            cnt++;
            chk9({tag, " doa during clear"}, bus0.doa, 9'h000);
            chk9({tag, " dob during clear"}, bus0.dob, 9'h000);
            chk1({tag, " collision during clear"}, bus0.collision, 1'b0);
        end
        if (bus0.init_busy) chk1({tag, " busy timeout"}, bus0.init_busy, 1'b0);
    endtask

    task automatic readback_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 4'd0, 9'h000, 1'b1, 1'b0, 4'(i), 9'h000);
            step();
            chk9($sformatf("%s addr %0d", tag, i), bus0.dob, 9'h000);
            $display("readback %s addr=%0d dob=%h", tag, i, bus0.dob);
        end
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        n_checks = 0;
        n_fail   = 0;
        idle();
        rst = 1'b1;
        step();
        step();
        chk9("reset doa", bus0.doa, 9'h000);
        chk9("reset dob", bus0.dob, 9'h000);
        chk1("reset collision", bus0.collision, 1'b0);
        chk1("reset init_busy", bus0.init_busy, 1'b1);
        chk9("reset doa outreg", bus2.doa, 9'h000);
        rst = 1'b0;
        count_busy("initial", cnt);
        chk_int("initial clear length", cnt, 16);
        $display("initial clear busy cycles=%0d", cnt);

        // Pre-fill, then a one-cycle reset must sweep everything back to zero.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 4'(i), 9'h1AA, 1'b0, 1'b0, 4'd0, 9'h000);
            step();
        end
        idle();
        chk9("prefill writethrough doa", bus1.doa, 9'h1AA);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk9("pulse reset doa writethrough", bus1.doa, 9'h000);
        chk1("pulse reset init_busy", bus0.init_busy, 1'b1);
        count_busy("sweep", cnt);
        chk_int("sweep clear length", cnt, 16);
        $display("sweep busy cycles=%0d", cnt);
        readback_zero("after sweep");

        //  A: ce we ad  di      B: ce we ad  di     doa0    dob0   col doa1    doa2    dob2
        add(1'b1,1'b1,4'd3,9'h155, 1'b0,1'b0,4'd0,9'h000, 9'h000,9'h000,1'b0,9'h155,9'h000,9'h000);
        add(1'b0,1'b0,4'd0,9'h000, 1'b1,1'b0,4'd3,9'h000, 9'h000,9'h155,1'b0,9'h155,9'h000,9'h000);
        add(1'b0,1'b0,4'd0,9'h000, 1'b0,1'b0,4'd0,9'h000, 9'h000,9'h155,1'b0,9'h155,9'h000,9'h155);
        add(1'b0,1'b0,4'd0,9'h000, 1'b0,1'b0,4'd0,9'h000, 9'h000,9'h155,1'b0,9'h155,9'h000,9'h155);
        add(1'b1,1'b0,4'd3,9'h000, 1'b0,1'b0,4'd0,9'h000, 9'h155,9'h155,1'b0,9'h155,9'h000,9'h155);
        add(1'b1,1'b1,4'd5,9'h00F, 1'b0,1'b0,4'd0,9'h000, 9'h155,9'h155,1'b0,9'h00F,9'h155,9'h155);
        add(1'b1,1'b1,4'd5,9'h0F0, 1'b0,1'b0,4'd0,9'h000, 9'h155,9'h155,1'b0,9'h0F0,9'h000,9'h155);
        add(1'b0,1'b0,4'd0,9'h000, 1'b0,1'b0,4'd0,9'h000, 9'h155,9'h155,1'b0,9'h0F0,9'h00F,9'h155);
        add(1'b1,1'b1,4'd7,9'h111, 1'b1,1'b1,4'd7,9'h0AA, 9'h155,9'h155,1'b1,9'h111,9'h00F,9'h155);
        add(1'b0,1'b0,4'd0,9'h000, 1'b0,1'b0,4'd0,9'h000, 9'h155,9'h155,1'b0,9'h111,9'h000,9'h000);
        add(1'b0,1'b0,4'd0,9'h000, 1'b1,1'b0,4'd7,9'h000, 9'h155,9'h111,1'b0,9'h111,9'h000,9'h000);
        add(1'b0,1'b0,4'd0,9'h000, 1'b0,1'b0,4'd0,9'h000, 9'h155,9'h111,1'b0,9'h111,9'h000,9'h111);
        add(1'b1,1'b1,4'd9,9'h033, 1'b0,1'b0,4'd0,9'h000, 9'h155,9'h111,1'b0,9'h033,9'h000,9'h111);
        add(1'b1,1'b1,4'd9,9'h077, 1'b1,1'b0,4'd9,9'h000, 9'h155,9'h033,1'b1,9'h077,9'h000,9'h111);
        add(1'b0,1'b0,4'd0,9'h000, 1'b0,1'b0,4'd0,9'h000, 9'h155,9'h033,1'b0,9'h077,9'h033,9'h033);
        add(1'b0,1'b0,4'd0,9'h000, 1'b1,1'b0,4'd9,9'h000, 9'h155,9'h077,1'b0,9'h077,9'h033,9'h033);
        add(1'b0,1'b0,4'd0,9'h000, 1'b0,1'b0,4'd0,9'h000, 9'h155,9'h077,1'b0,9'h077,9'h033,9'h077);
        add(1'b1,1'b0,4'd9,9'h000, 1'b1,1'b0,4'd9,9'h000, 9'h077,9'h077,1'b0,9'h077,9'h033,9'h077);
        add(1'b0,1'b0,4'd0,9'h000, 1'b0,1'b0,4'd0,9'h000, 9'h077,9'h077,1'b0,9'h077,9'h077,9'h077);
        add(1'b1,1'b0,4'd3,9'h000, 1'b1,1'b1,4'd3,9'h0CC, 9'h155,9'h077,1'b1,9'h155,9'h077,9'h077);
        add(1'b0,1'b0,4'd0,9'h000, 1'b0,1'b0,4'd0,9'h000, 9'h155,9'h077,1'b0,9'h155,9'h155,9'h155);
        add(1'b1,1'b0,4'd3,9'h000, 1'b0,1'b0,4'd0,9'h000, 9'h0CC,9'h077,1'b0,9'h0CC,9'h155,9'h155);
        add(1'b0,1'b0,4'd0,9'h000, 1'b0,1'b0,4'd0,9'h000, 9'h0CC,9'h077,1'b0,9'h0CC,9'h0CC,9'h155);

        foreach (vecs[i]) begin
            drive(vecs[i].cea, vecs[i].wea, vecs[i].addra, vecs[i].dia,
                  vecs[i].ceb, vecs[i].web, vecs[i].addrb, vecs[i].dib);
            step();
            chk9($sformatf("v%0d doa normal", i), bus0.doa, vecs[i].doa0);
            chk9($sformatf("v%0d dob normal", i), bus0.dob, vecs[i].dob0);
            chk1($sformatf("v%0d collision", i), bus0.collision, vecs[i].col);
            chk9($sformatf("v%0d doa writethrough", i), bus1.doa, vecs[i].doa1);
            chk9($sformatf("v%0d doa rbw outreg", i), bus2.doa, vecs[i].doa2);
            chk9($sformatf("v%0d dob rbw outreg", i), bus2.dob, vecs[i].dob2);
            $display("vec %0d: doa=%h dob=%h col=%b doa_wt=%h doa_rbw=%h dob_rbw=%h",
                     i, bus0.doa, bus0.dob, bus0.collision, bus1.doa, bus2.doa, bus2.dob);
        end
        idle();

        // Reset mid-sweep with hostile same-address writes held on both ports.
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b1, 1'b1, 4'd12, 9'h1FF, 1'b1, 1'b1, 4'd12, 9'h0AB);
        for (int k = 0; k < 5; k++) step();
        chk1("mid-clear still busy", bus0.init_busy, 1'b1);
        chk1("mid-clear collision", bus0.collision, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy("restart", cnt);
        idle();
        chk_int("restarted clear length", cnt, 16);
        $display("restart busy cycles=%0d", cnt);
        readback_zero("after restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
